cmd_sequencer: RTL

- Upstream instruction stage for Main_Module_1. Holds a small loadable program and issues one {command, in} pair per instruction to the register stage.
- Handles sequencer-local control instructions (jump, jump-if-R1-zero, wait, halt) itself and issues NOP for them.
- Reads R1_out back from the register stage for conditional branching.

---
 rtl/cpu_pkg.sv | 10 +
 rtl/prog_ram.sv | 19 +
 rtl/cmd_sequencer.sv | 94 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, sequencer state type and default field widths
package cpu_pkg;
    localparam int DEF_CMD_W  = 4;
    localparam int DEF_DATA_W = 8;
    localparam logic [DEF_CMD_W-1:0] OP_JMP  = 4'd12;
    localparam logic [DEF_CMD_W-1:0] OP_JZ   = 4'd13;
    localparam logic [DEF_CMD_W-1:0] OP_WAIT = 4'd14;
    localparam logic [DEF_CMD_W-1:0] OP_HALT = 4'd15;
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WAIT} state_t;
endpackage

// File: rtl/prog_ram.sv
// prog_ram: single write port, registered read port program memory
// ports: clock; we/waddr/wdata write side; raddr in, rdata out one cycle later
module prog_ram #(
    parameter int ADDR_W = 4,
    parameter int WORD_W = 12
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: runs a loadable program, issuing {command, operand} pairs to the register stage
// ports: clock, reset (sync, active-high); prog_we/prog_addr/prog_data load the program in IDLE;
//        start launches at address 0; r1_in feeds JZ; cmd_out/operand_out drive the register stage;
//        busy, done (HALT pulse) and pc_out report progress
module cmd_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int CMD_W  = DEF_CMD_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    prog_we,
    input  logic [ADDR_W-1:0]       prog_addr,
    input  logic [CMD_W+DATA_W-1:0] prog_data,
    input  logic                    start,
    input  logic [DATA_W-1:0]       r1_in,
    output logic [CMD_W-1:0]        cmd_out,
    output logic [DATA_W-1:0]       operand_out,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_W-1:0]       pc_out
);
    state_t state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [DATA_W-1:0] cnt, cnt_n;
    logic [CMD_W+DATA_W-1:0] word;
    logic [CMD_W-1:0] op;
    logic [DATA_W-1:0] arg;
    logic [ADDR_W-1:0] pc_inc;
    prog_ram #(.ADDR_W(ADDR_W), .WORD_W(CMD_W+DATA_W)) u_ram (
        .clock(clock),
        .we(prog_we && state == IDLE),
        .waddr(prog_addr),
        .wdata(prog_data),
        .raddr(pc),
        .rdata(word)
    );
    assign op     = word[CMD_W+DATA_W-1 -: CMD_W];
    assign arg    = word[DATA_W-1:0];
    assign pc_inc = pc + ADDR_W'(1);
    assign busy   = state != IDLE;
    assign pc_out = pc;
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            pc    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            cnt   <= cnt_n;
        end
    end
    // outputs come straight from the state and RAM read registers, so they are
    // only non-zero for the single EXEC cycle of a pass-through word
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        cnt_n       = cnt;
        cmd_out     = '0;
        operand_out = '0;
        done        = 1'b0;
        if (state == IDLE) begin
            state_n = start ? FETCH : IDLE;
            pc_n    = start ? '0 : pc;
        end else if (state == FETCH) begin
            state_n = EXEC;
        end else if (state == EXEC) begin
            state_n = FETCH;
            pc_n    = pc_inc;
            if (op < OP_JMP) begin
                cmd_out     = op;
                operand_out = arg;
            end else if (op == OP_JMP) begin
                pc_n = arg[ADDR_W-1:0];
            end else if (op == OP_JZ) begin
                pc_n = (r1_in == '0) ? arg[ADDR_W-1:0] : pc_inc;
            end else if (op == OP_WAIT) begin
                state_n = (arg == '0) ? FETCH : WAIT;
                cnt_n   = arg;
            end else if (op == OP_HALT) begin
                state_n = IDLE;
                pc_n    = pc;
                done    = 1'b1;
            end
        end else begin
            // one WAIT cycle per count; leave after the cycle that sees 1
            cnt_n   = cnt - DATA_W'(1);
            state_n = (cnt == DATA_W'(1)) ? FETCH : WAIT;
        end
    end
endmodule
